// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package ifetch_unit_pkg;

  localparam int unsigned DEF_ADD_WIDTH  = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_RESET_PC   = 0;
  localparam longint unsigned IMEM_WORDS = 64'd1 << DEF_ADD_WIDTH;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] pc;
    logic [DEF_DATA_WIDTH-1:0] instr;
    logic                      fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding prefetched instructions; flush wins over push.
module ifetch_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [Width-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A full buffer can still accept a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, reads the async instruction
// memory and queues fetched words for decode through a valid/ready handshake.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned addWidth  = DEF_ADD_WIDTH,
  parameter int unsigned dataWidth = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned RESET_PC  = DEF_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [dataWidth-1:0] mem_addr,
  input  logic [dataWidth-1:0] mem_rdata,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [dataWidth-1:0] redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [dataWidth-1:0] instr,
  output logic [dataWidth-1:0] instr_pc,
  output logic                 instr_fault
);

  typedef struct packed {
    logic [dataWidth-1:0] pc;
    logic [dataWidth-1:0] instr;
    logic                 fault;
  } entry_t;

  logic [dataWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic                 push, pop, full, empty, fault;
  entry_t               wr_entry, head;

  // Out of range means any address bit at or above addWidth is set.
  if (addWidth < dataWidth) begin : g_fault
    assign fault = |fetch_pc_q[dataWidth-1:addWidth];
  end else begin : g_no_fault
    assign fault = 1'b0;
  end

  assign mem_addr    = fetch_pc_q;
  assign instr_valid = ~empty;
  assign pop         = instr_valid & instr_ready;
  assign push        = fetch_en & ~redirect_valid & (~full | pop);
  assign wr_entry    = '{pc: fetch_pc_q, instr: mem_rdata, fault: fault};
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_fault = head.fault;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + dataWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= dataWidth'(RESET_PC);
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  ifetch_fifo #(
    .Width($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata(wr_entry),
    .full (full),
    .empty(empty),
    .head (head)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a queue-based buffer model predicts every
// entry; a negedge monitor compares the head and retires consumed entries.
module tb_ifetch_unit;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;
  logic          fetch_en, redirect_valid, instr_valid, instr_ready, instr_fault;

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] ins;
    logic          f;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_pc;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] imem(input logic [DW-1:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign mem_rdata = imem(mem_addr);

  ifetch_unit #(
    .addWidth (AW),
    .dataWidth(DW),
    .DEPTH    (DEPTH),
    .RESET_PC (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_fault   (instr_fault)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare the DUT head against the model buffer, retire on handshake.
  always @(negedge clk) begin
    check("mem_addr", mem_addr, model_pc);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, sb.size() != 0});
    if (sb.size() != 0) begin
      check("instr_pc", instr_pc, sb[0].pc);
      check("instr", instr, sb[0].ins);
      check("instr_fault", {31'b0, instr_fault}, {31'b0, sb[0].f});
    end else begin
      check("instr_pc_empty", instr_pc, '0);
      check("instr_empty", instr, '0);
      check("instr_fault_empty", {31'b0, instr_fault}, '0);
    end
    if (rst_n && instr_ready && sb.size() != 0) void'(sb.pop_front());
  end

  // One clock of stimulus; the model applies the upcoming edge after the monitor ran.
  task automatic cycle(input logic en, input logic rv, input logic [DW-1:0] rpc,
                       input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    fetch_en       = en;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    @(negedge clk);
    #1;
    if (rv) begin
      sb.delete();
      model_pc = rpc;
    end else if (en && sb.size() < DEPTH) begin
      e.pc  = model_pc;
      e.ins = imem(model_pc);
      e.f   = ({32'b0, model_pc} >= (64'd1 << AW));
      sb.push_back(e);
      model_pc = model_pc + 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    sb.delete();
    model_pc = '0;
    #1;
    check("rst_valid", {31'b0, instr_valid}, '0);
    check("rst_instr", instr, '0);
    check("rst_pc", instr_pc, '0);
    check("rst_fault", {31'b0, instr_fault}, '0);
    check("rst_mem_addr", mem_addr, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    model_pc       = '0;
    #12 rst_n = 1'b1;

    // Straight-line fetch
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b1);
    // Back-pressure then drain
    do_reset();
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b1);
    // Redirect with a full buffer
    repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 32'd20, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    // Run across the end of memory
    cycle(1'b1, 1'b1, 32'd30, 1'b1);
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);
    // Fetch disabled: drain, then redirect while disabled
    repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 32'd7, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);
    // PC wrap from all-ones
    cycle(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    // Mid-stream reset
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic          en, rv, rdy;
      logic [DW-1:0] rpc;
      en  = ($urandom_range(0, 99) < 80);
      rdy = ($urandom_range(0, 99) < 70);
      rv  = ($urandom_range(0, 99) < 8);
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD : DW'($urandom_range(0, 40));
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle(en, rv, rpc, rdy);
    end

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
